// File: rtl/spiking_pkg.sv
// Shared definitions for the spiking PE array and its timestep scheduler:
// FSM state encoding, default geometry and the stream-length helper.
package spiking_pkg;

  localparam int ROWS_DEF        = 4;
  localparam int COLS_DEF        = 4;
  localparam int TSTEP_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_WAIT_SPK = 3'd2,
    ST_STREAM   = 3'd3,
    ST_LEAK     = 3'd4,
    ST_FIRE     = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // Cycles for the last row's spike to cross the last column.
  function automatic int stream_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/spike_skew_buf.sv
// Holds one captured spike vector and releases bit r to row r only in the
// stream cycle whose index equals r, producing the diagonal skew.
module spike_skew_buf #(
  parameter int ROWS = 4,
  parameter int CW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [ROWS-1:0] i_vec,
  input  logic            i_en,
  input  logic [CW-1:0]   i_cnt,
  output logic [ROWS-1:0] o_row
);

  logic [ROWS-1:0] r_vec;

  // Capture register, loaded on the accepted handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec <= {ROWS{1'b0}};
    end else if (i_load) begin
      r_vec <= i_vec;
    end else begin
      r_vec <= r_vec;
    end
  end

  always_comb begin
    o_row = {ROWS{1'b0}};
    for (int r = 0; r < ROWS; r++) begin
      o_row[r] = i_en && r_vec[r] && (i_cnt == CW'(r));
    end
  end

endmodule

// File: rtl/spiking_array_ctrl.sv
// Timestep scheduler for a ROWS x COLS spiking systolic array.
// Optional macro SPIKING_ARRAY_CTRL_LEAK_EN adds a leak strobe/state before fire.
module spiking_array_ctrl
  import spiking_pkg::*;
#(
  parameter int ROWS        = ROWS_DEF,
  parameter int COLS        = COLS_DEF,
  parameter int TSTEP_WIDTH = TSTEP_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [TSTEP_WIDTH-1:0] num_tsteps,
  input  logic                   spk_valid,
  input  logic [ROWS-1:0]        spk_in,
  output logic                   spk_ready,
  output logic [ROWS-1:0]        row_spk,
  output logic                   clr_mem,
  output logic                   fire,
  output logic                   busy,
  output logic                   done,
  output logic [TSTEP_WIDTH-1:0] tstep_cnt
`ifdef SPIKING_ARRAY_CTRL_LEAK_EN
  ,
  output logic                   leak
`endif
);

  localparam int SLEN = stream_len(ROWS, COLS);
  localparam int SCW  = $clog2(ROWS + COLS);
  localparam logic [SCW-1:0] SCNT_LAST = SCW'(SLEN - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [SCW-1:0]         r_scnt;
  logic [TSTEP_WIDTH-1:0] r_num;
  logic [TSTEP_WIDTH-1:0] r_tstep;
  logic [TSTEP_WIDTH-1:0] w_tstep_inc;
  logic                   w_hs;
  logic                   w_stream_last;
  logic                   w_streaming;

  assign w_hs          = (r_state == ST_WAIT_SPK) && spk_valid;
  assign w_stream_last = (r_scnt == SCNT_LAST);
  assign w_streaming   = (r_state == ST_STREAM);
  assign w_tstep_inc   = r_tstep + TSTEP_WIDTH'(1);
  assign tstep_cnt     = r_tstep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     w_next = start ? ST_CLEAR : ST_IDLE;
      ST_CLEAR:    w_next = (r_num == {TSTEP_WIDTH{1'b0}}) ? ST_DONE : ST_WAIT_SPK;
      ST_WAIT_SPK: w_next = w_hs ? ST_STREAM : ST_WAIT_SPK;
`ifdef SPIKING_ARRAY_CTRL_LEAK_EN
      ST_STREAM:   w_next = w_stream_last ? ST_LEAK : ST_STREAM;
      ST_LEAK:     w_next = ST_FIRE;
`else
      ST_STREAM:   w_next = w_stream_last ? ST_FIRE : ST_STREAM;
`endif
      // Compare the post-increment count so num_tsteps = 2^W-1 never wraps.
      ST_FIRE:     w_next = (w_tstep_inc == r_num) ? ST_DONE : ST_WAIT_SPK;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    spk_ready = 1'b0;
    clr_mem   = 1'b0;
    fire      = 1'b0;
    done      = 1'b0;
    busy      = (r_state != ST_IDLE);
`ifdef SPIKING_ARRAY_CTRL_LEAK_EN
    leak      = 1'b0;
`endif
    case (r_state)
      ST_CLEAR:    clr_mem   = 1'b1;
      ST_WAIT_SPK: spk_ready = 1'b1;
`ifdef SPIKING_ARRAY_CTRL_LEAK_EN
      ST_LEAK:     leak      = 1'b1;
`endif
      ST_FIRE:     fire      = 1'b1;
      ST_DONE:     done      = 1'b1;
      default:     spk_ready = 1'b0;
    endcase
  end

  // Stream cycle counter; idles at zero so every timestep starts from row 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scnt <= {SCW{1'b0}};
    end else if (w_streaming && !w_stream_last) begin
      r_scnt <= r_scnt + SCW'(1);
    end else begin
      r_scnt <= {SCW{1'b0}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num   <= {TSTEP_WIDTH{1'b0}};
      r_tstep <= {TSTEP_WIDTH{1'b0}};
    end else if ((r_state == ST_IDLE) && start) begin
      r_num   <= num_tsteps;
      r_tstep <= {TSTEP_WIDTH{1'b0}};
    end else if (r_state == ST_FIRE) begin
      r_num   <= r_num;
      r_tstep <= w_tstep_inc;
    end else begin
      r_num   <= r_num;
      r_tstep <= r_tstep;
    end
  end

  spike_skew_buf #(
    .ROWS (ROWS),
    .CW   (SCW)
  ) u_skew (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_hs),
    .i_vec  (spk_in),
    .i_en   (w_streaming),
    .i_cnt  (r_scnt),
    .o_row  (row_spk)
  );

endmodule

// File: doc/spiking_array_ctrl.md
# spiking_array_ctrl

Timestep scheduler for a ROWS x COLS systolic array of spiking PEs. Each timestep it accepts one spike vector over a valid/ready handshake and drives it into the array rows with per-row skew. It waits for the spikes to propagate across all columns, then issues a fire pulse. It repeats this for a programmed number of timesteps. It sits between the spike input stream and the PE array, and is the only block that drives the array's row inputs and membrane control strobes.

## Interface
- ROWS, 4, array rows (1..32)
- COLS, 4, array columns (1..32)
- TSTEP_WIDTH, 8, width of timestep count
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- num_tsteps  in  TSTEP_WIDTH  timesteps per run; latched on accepted start
- spk_valid  in  1  spike vector valid
- spk_in  in  ROWS  spike vector, bit r for row r
- spk_ready  out  1  controller accepts spike vector
- row_spk  out  ROWS  skewed spike bits to array in_row inputs
- clr_mem  out  1  clear all membrane potentials
- fire  out  1  threshold-compare/fire strobe to array
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at run end
- tstep_cnt  out  TSTEP_WIDTH  completed timesteps in current run

## Operation
- States: IDLE, CLEAR, WAIT_SPK, STREAM, (LEAK), FIRE, DONE.
- IDLE: start=1 latches num_tsteps, zeroes tstep_cnt and goes to CLEAR. While not in IDLE, start is ignored.
- CLEAR: clr_mem=1 for exactly one cycle.
  - If the latched num_tsteps==0, go to DONE. No spike vector is accepted.
  - Otherwise go to WAIT_SPK.
- WAIT_SPK: spk_ready=1. When spk_valid&&spk_ready, spk_in is captured into the skew buffer and the FSM goes to STREAM. spk_ready is 0 in every other state.
- STREAM: lasts exactly ROWS+COLS-1 cycles, timed by a stream counter starting at 0.
  - row_spk[r] = captured bit r only in stream cycle r; 0 otherwise.
  - The last row's spike reaches the last column in the final cycle.
- FIRE: fire=1 for one cycle, tstep_cnt increments.
  - If the new count equals the latched num_tsteps, go to DONE.
  - Otherwise go to WAIT_SPK.
- DONE: done=1 for one cycle, then IDLE. tstep_cnt holds its final value until the next accepted start.
- All outputs are Moore-decoded from registered state and counters. There are no combinational paths from inputs to outputs except through state.
- Counter arithmetic:
  - tstep_cnt is an unsigned TSTEP_WIDTH compare against the latched value, so the maximum num_tsteps = 2^TSTEP_WIDTH-1 with no wrap.
  - The stream counter width is clog2(ROWS+COLS).
- Reset (any time, including mid-STREAM): state=IDLE. spk_ready, row_spk, clr_mem, fire, busy, done and tstep_cnt all go to 0. The skew buffer is cleared. A partially streamed timestep is discarded.
- spk_in changes while spk_ready=0 have no effect.

## Timing
- start accepted at cycle 0 → CLEAR at cycle 1 (clr_mem=1) → WAIT_SPK at cycle 2.
- Handshake in cycle t → STREAM cycles t+1..t+ROWS+COLS-1 → FIRE at t+ROWS+COLS.
- Timestep period with spk_valid held high: ROWS+COLS+1 cycles (ROWS+COLS+2 with leak enabled).
- With spk_valid low, the controller waits in WAIT_SPK indefinitely. row_spk stays 0.
- done is asserted the cycle after the final FIRE. busy falls in the cycle after done.

## Configuration
- SPIKING_ARRAY_CTRL_LEAK_EN defined:
  - Adds output leak (1 bit) and a LEAK state between STREAM and FIRE.
  - leak=1 for one cycle, instructing the PEs to apply membrane decay before firing.
- Undefined: no leak port, no LEAK state; STREAM goes directly to FIRE.

## Structure
- Shared package spiking_pkg: FSM state enum, default ROWS/COLS/TSTEP_WIDTH constants and the stream-length function ROWS+COLS-1. The PE array and its testbench use the same package.
- One sub-module, spike_skew_buf:
  - Loads a ROWS-bit vector.
  - Given the stream counter, outputs bit r only when the counter equals r.
  - It is cleared by rst.

## Test plan
- Basic run, ROWS=COLS=4, num_tsteps=2, spk_valid always 1, spk_in=4'b1011:
  - clr_mem at cycle 1.
  - row_spk shows bit0,bit1,0,bit3 on successive stream cycles, i.e. 1,1,0,1 in cycles 0,1,2,3 (each row pulsed once).
  - fire every 9 cycles.
  - done once, with tstep_cnt=2.
- num_tsteps=0: clr_mem, then done two cycles after start. spk_ready never asserts.
- Backpressure: spk_valid low for 5 cycles in WAIT_SPK → spk_ready stays 1, row_spk stays 0, fire is delayed by exactly 5 cycles.
- start pulsed while busy → ignored. The run completes with the originally latched num_tsteps.
- rst asserted in the middle of the 3rd STREAM cycle → all outputs 0 immediately. A later start begins a fresh run with tstep_cnt=0.
- With SPIKING_ARRAY_CTRL_LEAK_EN: leak pulses one cycle before each fire and the period becomes 10 cycles. Without the macro the period is 9 cycles.
